// File: rtl/regs_mp_pkg.sv
// regs_mp_pkg: shared constants for the physical register file.
//   LEN_PREG_ADDR      physical register address width
//   LEN_WORD           machine word width
//   LEN_MEMDATA_ADDR   data-memory address width (sets the initial stack top)
//   HEAP_POINTER_INIT  initial heap pointer
//   PREG_INIT_DEFAULT  flat reset-value vector; slice k-1 is the reset value of
//                      register k. The core and the testbench both use it.
package regs_mp_pkg;

  localparam int LEN_PREG_ADDR    = 5;
  localparam int LEN_WORD         = 32;
  localparam int LEN_MEMDATA_ADDR = 12;

  localparam logic [LEN_WORD-1:0] HEAP_POINTER_INIT = 32'h0001_0000;

  localparam int N_INIT_DEFAULT = 3;

  // r1 = 0, r2 = top of data memory, r3 = heap pointer
  localparam logic [N_INIT_DEFAULT*LEN_WORD-1:0] PREG_INIT_DEFAULT =
    {HEAP_POINTER_INIT, 32'b100 << LEN_MEMDATA_ADDR, 32'b0};

endpackage

// File: rtl/regs_mp_wsel.sv
// regs_mp_wsel: combinational priority select over the write ports.
//   addr     address being looked up
//   wr_en    per-port write enables
//   wr_addr  flat per-port write addresses
//   wr_data  flat per-port write data
//   hit      1 = at least one enabled port targets addr
//   data     data of the highest-index matching port ('0 when no hit)
module regs_mp_wsel #(
  parameter int N_WR     = 2,
  parameter int LEN_ADDR = 5,
  parameter int LEN_DATA = 32
) (
  input  logic [LEN_ADDR-1:0]      addr,
  input  logic [N_WR-1:0]          wr_en,
  input  logic [N_WR*LEN_ADDR-1:0] wr_addr,
  input  logic [N_WR*LEN_DATA-1:0] wr_data,
  output logic                     hit,
  output logic [LEN_DATA-1:0]      data
);

  // Ascending scan: a later (higher-index) match overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int j = 0; j < N_WR; j++) begin
      if (wr_en[j] && (wr_addr[j*LEN_ADDR +: LEN_ADDR] == addr)) begin
        hit  = 1'b1;
        data = wr_data[j*LEN_DATA +: LEN_DATA];
      end
    end
  end

endmodule

// File: rtl/regs_mp.sv
// regs_mp: multi-port physical register file with a busy-bit scoreboard.
//   clk, rst    clock, synchronous active-high reset
//   rd_addr     flat read addresses (slice i = port i)
//   rd_data     flat read data, combinational
//   rd_busy     per read port: register has an outstanding producer
//   wr_en/wr_addr/wr_data  write ports; highest index wins on collision
//   claim_en/claim_addr    mark a destination busy (takes effect next cycle)
//   flush       clear all busy bits (a same-cycle claim still survives)
//   busy_cnt    number of busy registers
// Register 0 is hardwired to zero and never busy.
module regs_mp
  import regs_mp_pkg::*;
#(
  parameter int N_RD     = 2,
  parameter int N_WR     = 2,
  parameter int LEN_ADDR = LEN_PREG_ADDR,
  parameter int LEN_DATA = LEN_WORD,
  parameter int N_INIT   = N_INIT_DEFAULT,
  parameter logic [N_INIT*LEN_DATA-1:0] INIT_VALUES = PREG_INIT_DEFAULT,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_RD*LEN_ADDR-1:0] rd_addr,
  output logic [N_RD*LEN_DATA-1:0] rd_data,
  output logic [N_RD-1:0]          rd_busy,
  input  logic [N_WR-1:0]          wr_en,
  input  logic [N_WR*LEN_ADDR-1:0] wr_addr,
  input  logic [N_WR*LEN_DATA-1:0] wr_data,
  input  logic                     claim_en,
  input  logic [LEN_ADDR-1:0]      claim_addr,
  input  logic                     flush,
  output logic [LEN_ADDR:0]        busy_cnt
);

  localparam int DEPTH = 1 << LEN_ADDR;

  logic [LEN_DATA-1:0]             regs [DEPTH];
  logic [DEPTH-1:0]                busy;
  logic [DEPTH-1:0]                st_hit;
  logic [DEPTH-1:0][LEN_DATA-1:0]  st_data;

  function automatic logic [LEN_DATA-1:0] reset_value(input int r);
    logic [N_INIT*LEN_DATA-1:0] iv;
    iv = INIT_VALUES;
    if (r >= 1 && r <= N_INIT) return iv[(r-1)*LEN_DATA +: LEN_DATA];
    return '0;
  endfunction

  // Per-register write select; register 0 never sees a write.
  assign st_hit[0]  = 1'b0;
  assign st_data[0] = '0;

  for (genvar r = 1; r < DEPTH; r++) begin : g_store
    regs_mp_wsel #(.N_WR(N_WR), .LEN_ADDR(LEN_ADDR), .LEN_DATA(LEN_DATA)) u_wsel (
      .addr    (LEN_ADDR'(r)),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .hit     (st_hit[r]),
      .data    (st_data[r])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= reset_value(r);
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (st_hit[r]) regs[r] <= st_data[r];
      end
    end
  end

  // Busy scoreboard: claim beats flush, flush beats write-completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy[0] <= 1'b0;
      for (int r = 1; r < DEPTH; r++) begin
        if (claim_en && (claim_addr == LEN_ADDR'(r))) busy[r] <= 1'b1;
        else if (flush)                               busy[r] <= 1'b0;
        else if (st_hit[r])                           busy[r] <= 1'b0;
      end
    end
  end

  always_comb begin
    busy_cnt = '0;
    for (int r = 0; r < DEPTH; r++) busy_cnt = busy_cnt + (LEN_ADDR+1)'(busy[r]);
  end

  for (genvar i = 0; i < N_RD; i++) begin : g_read
    logic [LEN_ADDR-1:0] ra;
    logic                byp_hit;
    logic [LEN_DATA-1:0] byp_data;
    logic [LEN_DATA-1:0] d;
    logic                b;

    assign ra = rd_addr[i*LEN_ADDR +: LEN_ADDR];

    regs_mp_wsel #(.N_WR(N_WR), .LEN_ADDR(LEN_ADDR), .LEN_DATA(LEN_DATA)) u_byp (
      .addr    (ra),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .hit     (byp_hit),
      .data    (byp_data)
    );

    // A completing write forwards its data and hides the busy bit it clears.
    always_comb begin
      d = regs[ra];
      b = busy[ra];
      if ((BYPASS != 0) && byp_hit && (ra != '0)) begin
        d = byp_data;
        b = 1'b0;
      end
    end

    assign rd_data[i*LEN_DATA +: LEN_DATA] = d;
    assign rd_busy[i]                      = b;
  end

endmodule

// File: tb/tb_regs_mp.sv
// tb_regs_mp: drives a bypassing and a non-bypassing regs_mp with the same
// inputs and compares both against a behavioural register-file model.
module tb_regs_mp;
  import regs_mp_pkg::*;

  localparam int N_RD  = 2;
  localparam int N_WR  = 2;
  localparam int LA    = LEN_PREG_ADDR;
  localparam int LD    = LEN_WORD;
  localparam int DEPTH = 1 << LA;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic [N_RD*LA-1:0]     rd_addr;
  logic [N_WR-1:0]        wr_en;
  logic [N_WR*LA-1:0]     wr_addr;
  logic [N_WR*LD-1:0]     wr_data;
  logic                   claim_en;
  logic [LA-1:0]          claim_addr;
  logic                   flush;

  logic [N_RD*LD-1:0]     rd_data_b, rd_data_n;
  logic [N_RD-1:0]        rd_busy_b, rd_busy_n;
  logic [LA:0]            busy_cnt_b, busy_cnt_n;

  regs_mp #(.BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .claim_en(claim_en),
    .claim_addr(claim_addr), .flush(flush), .busy_cnt(busy_cnt_b)
  );

  regs_mp #(.BYPASS(0)) u_nobyp (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .claim_en(claim_en),
    .claim_addr(claim_addr), .flush(flush), .busy_cnt(busy_cnt_n)
  );

  // ---------------- reference model ----------------
  logic [LD-1:0] m_regs [DEPTH];
  bit            m_busy [DEPTH];

  function automatic logic [LD-1:0] init_of(input int r);
    logic [N_INIT_DEFAULT*LD-1:0] iv;
    iv = PREG_INIT_DEFAULT;
    if (r >= 1 && r <= N_INIT_DEFAULT) return iv[(r-1)*LD +: LD];
    return '0;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int r = 0; r < DEPTH; r++) c += int'(m_busy[r]);
    return c;
  endfunction

  // What a read of address a should show this cycle.
  task automatic exp_read(input int bypass, input int a, output logic [LD-1:0] d, output logic b);
    d = m_regs[a];
    b = m_busy[a];
    if (a == 0) begin
      d = '0;
      b = 1'b0;
    end else if (bypass != 0) begin
      for (int j = 0; j < N_WR; j++) begin
        if (wr_en[j] && int'(wr_addr[j*LA +: LA]) == a) begin
          d = wr_data[j*LD +: LD];
          b = 1'b0;
        end
      end
    end
  endtask

  // Advance the model by one clock edge using the current inputs.
  task automatic model_step();
    bit written [DEPTH];
    int a;
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        m_regs[r] = init_of(r);
        m_busy[r] = 1'b0;
      end
    end else begin
      for (int r = 0; r < DEPTH; r++) written[r] = 1'b0;
      for (int j = 0; j < N_WR; j++) begin
        a = int'(wr_addr[j*LA +: LA]);
        if (wr_en[j] && a != 0) begin
          m_regs[a]  = wr_data[j*LD +: LD];
          written[a] = 1'b1;
        end
      end
      for (int r = 0; r < DEPTH; r++) begin
        if (flush || written[r]) m_busy[r] = 1'b0;
      end
      if (claim_en && claim_addr != '0) m_busy[int'(claim_addr)] = 1'b1;
    end
  endtask

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [LD-1:0] exp_q [$];

  task automatic check(input string tag, input logic [LD-1:0] obs, input logic [LD-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [LD-1:0] ed;
    logic          eb;
    for (int bp = 1; bp >= 0; bp--) begin
      for (int i = 0; i < N_RD; i++) begin
        exp_read(bp, int'(rd_addr[i*LA +: LA]), ed, eb);
        exp_q.push_back(ed);
        exp_q.push_back(LD'(eb));
      end
      exp_q.push_back(LD'(m_count()));
    end
    for (int i = 0; i < N_RD; i++) begin
      check($sformatf("byp_data%0d", i), rd_data_b[i*LD +: LD], exp_q.pop_front());
      check($sformatf("byp_busy%0d", i), LD'(rd_busy_b[i]), exp_q.pop_front());
    end
    check("byp_cnt", LD'(busy_cnt_b), exp_q.pop_front());
    for (int i = 0; i < N_RD; i++) begin
      check($sformatf("nob_data%0d", i), rd_data_n[i*LD +: LD], exp_q.pop_front());
      check($sformatf("nob_busy%0d", i), LD'(rd_busy_n[i]), exp_q.pop_front());
    end
    check("nob_cnt", LD'(busy_cnt_n), exp_q.pop_front());
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    rst = 1'b0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    claim_en = 1'b0; claim_addr = '0; flush = 1'b0;
  endtask

  task automatic set_rd(input int i, input int a);
    rd_addr[i*LA +: LA] = LA'(a);
  endtask

  task automatic set_wr(input int j, input int a, input logic [LD-1:0] d);
    wr_en[j] = 1'b1;
    wr_addr[j*LA +: LA] = LA'(a);
    wr_data[j*LD +: LD] = d;
  endtask

  task automatic set_claim(input int a);
    claim_en = 1'b1;
    claim_addr = LA'(a);
  endtask

  // Inputs are set just after a falling edge; outputs are sampled 2 ns later,
  // well before the next rising edge.
  task automatic do_cycle(input bit chk);
    #2;
    if (chk) check_outputs();
    model_step();
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    set_idle();
    @(negedge clk);
    rst = 1'b1;
    do_cycle(1'b0);

    // reset values
    set_idle(); set_rd(0, 1); set_rd(1, 2);
    #1;
    check("rst_r1", rd_data_b[0 +: LD], '0);
    check("rst_r2", rd_data_b[LD +: LD], 32'd4 << LEN_MEMDATA_ADDR);
    check("rst_cnt", LD'(busy_cnt_b), '0);
    do_cycle(1'b1);
    set_idle(); set_rd(0, 3); set_rd(1, 5);
    #1;
    check("rst_r3", rd_data_n[0 +: LD], HEAP_POINTER_INIT);
    check("rst_r5", rd_data_n[LD +: LD], '0);
    do_cycle(1'b1);

    // write with same-cycle read, then the stored value
    set_idle(); set_wr(0, 7, 32'hDEAD_BEEF); set_rd(0, 7);
    #1;
    check("byp_r7", rd_data_b[0 +: LD], 32'hDEAD_BEEF);
    do_cycle(1'b1);
    set_idle(); set_rd(0, 7); do_cycle(1'b1);

    // write collision on r9
    set_idle(); set_wr(0, 9, 32'h1); set_wr(1, 9, 32'h2); set_rd(1, 9);
    #1;
    check("coll_byp", rd_data_b[LD +: LD], 32'h2);
    do_cycle(1'b1);
    set_idle(); set_rd(0, 9); do_cycle(1'b1);

    // register 0 ignores writes and claims
    set_idle(); set_wr(0, 0, 32'hFFFF_FFFF); set_claim(0); set_rd(0, 0); do_cycle(1'b1);
    set_idle(); set_rd(0, 0); do_cycle(1'b1);

    // claim r4, then write+claim r4 in one cycle
    set_idle(); set_claim(4); set_rd(0, 4); do_cycle(1'b1);
    set_idle(); set_rd(0, 4);
    #1;
    check("claim_r4_busy", LD'(rd_busy_b[0]), 32'd1);
    do_cycle(1'b1);
    set_idle(); set_wr(1, 4, 32'h4444); set_claim(4); set_rd(0, 4); do_cycle(1'b1);
    set_idle(); set_rd(0, 4); set_rd(1, 4); do_cycle(1'b1);

    // claims over three cycles, then flush + claim, then reset mid-sequence
    set_idle(); set_claim(5); do_cycle(1'b1);
    set_idle(); set_claim(6); do_cycle(1'b1);
    set_idle(); set_claim(8); set_rd(0, 5); set_rd(1, 6); do_cycle(1'b1);
    set_idle(); set_flush_claim10();
    do_cycle(1'b1);
    set_idle(); set_rd(0, 10); set_rd(1, 5); do_cycle(1'b1);
    set_idle(); set_claim(11); set_wr(0, 2, 32'h1234); do_cycle(1'b1);
    set_idle(); rst = 1'b1; set_claim(12); set_wr(1, 3, 32'h5555); flush = 1'b1; do_cycle(1'b1);
    set_idle(); set_rd(0, 2); set_rd(1, 3); do_cycle(1'b1);

    // randomized traffic; addresses biased low for collisions
    for (int n = 0; n < 1500; n++) begin
      set_idle();
      for (int i = 0; i < N_RD; i++)
        set_rd(i, ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH-1) : $urandom_range(0, 7));
      for (int j = 0; j < N_WR; j++)
        if ($urandom_range(0, 1) == 1)
          set_wr(j, ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH-1) : $urandom_range(0, 7), $urandom);
      if ($urandom_range(0, 2) == 0) set_claim($urandom_range(0, 9));
      flush = ($urandom_range(0, 19) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      do_cycle(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  task automatic set_flush_claim10();
    flush = 1'b1;
    set_claim(10);
  endtask

endmodule
